// File: rtl/operand_encoder_pkg.sv
// operand_encoder_pkg: operand-mode codes, FSM states and widths shared by the
// operand encoder and the operand handler.
package operand_encoder_pkg;
  localparam int IMM_W = 21;
  localparam int SHAMT_W = 5;
  typedef enum logic [2:0] {
    S_EQ     = 3'd0,
    S_SIMM10 = 3'd1,
    S_SIMM13 = 3'd2,
    S_HI21   = 3'd3,
    S_SRL    = 3'd4,
    S_SRA    = 3'd5,
    S_SLL    = 3'd6,
    S_ZERO   = 3'd7
  } mode_e;
  typedef enum logic [1:0] {IDLE, CHECK, SEARCH, DONE} state_e;
  function automatic logic is_search(mode_e s);
    return s inside {S_SRL, S_SRA, S_SLL};
  endfunction
  // True when n survives truncation to a w-bit two's-complement field.
  function automatic logic fits_signed(logic [31:0] n, int w);
    logic [31:0] t;
    t = $signed(n) >>> (w - 1);
    return t == '0 || t == '1;
  endfunction
endpackage

// File: rtl/operand_encoder_if.sv
// operand_encoder_if: request/result handshake bundle of the operand encoder.
import operand_encoder_pkg::*;
interface operand_encoder_if;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      N;
  logic [31:0]      RB;
  logic [2:0]       S;
  logic             out_valid;
  logic             out_ready;
  logic [IMM_W-1:0] I;
  logic             ok;
  modport master (output in_valid, N, RB, S, out_ready, input in_ready, out_valid, I, ok);
  modport slave  (input in_valid, N, RB, S, out_ready, output in_ready, out_valid, I, ok);
endinterface

// File: rtl/operand_encoder_oh_shifter.sv
// oh_shifter: register shift used by the operand handler for modes 4/5/6.
module oh_shifter
  import operand_encoder_pkg::*;
(
  input  logic [31:0]        rb,
  input  mode_e              s,
  input  logic [SHAMT_W-1:0] amt,
  output logic [31:0]        y
);
  logic [31:0] sra;
  assign sra = $signed(rb) >>> amt;
  always_comb y = s == S_SRL ? rb >> amt : s == S_SRA ? sra : s == S_SLL ? rb << amt : '0;
endmodule

// File: rtl/operand_encoder.sv
// operand_encoder: finds the immediate field I that makes the operand handler
// reproduce N in mode S, checking directly or searching all shift amounts.
module operand_encoder
  import operand_encoder_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  operand_encoder_if.slave bus
);
  state_e             state_q, state_d;
  logic [SHAMT_W-1:0] amt_q, amt_d;
  logic [31:0]        n_q, n_d, rb_q, rb_d;
  mode_e              s_q, s_d;
  logic [IMM_W-1:0]   i_q, i_d, chk_i;
  logic               ok_q, ok_d, chk_ok, hit;
  logic [31:0]        sh;

  oh_shifter u_sh (.rb(rb_q), .s(s_q), .amt(amt_q), .y(sh));

  assign hit = sh == n_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      amt_q   <= '0;
      n_q     <= '0;
      rb_q    <= '0;
      s_q     <= S_EQ;
      i_q     <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      amt_q   <= amt_d;
      n_q     <= n_d;
      rb_q    <= rb_d;
      s_q     <= s_d;
      i_q     <= i_d;
      ok_q    <= ok_d;
    end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = is_search(mode_e'(bus.S)) ? SEARCH : CHECK;
      CHECK:   state_d = DONE;
      SEARCH:  if (hit || amt_q == '1) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Direct encodability of the non-shift modes, evaluated on the captured request.
  always_comb begin
    chk_ok = 1'b0;
    chk_i  = '0;
    case (s_q)
      S_EQ:     chk_ok = n_q == rb_q;
      S_SIMM10: begin
        chk_ok = fits_signed(n_q, 10);
        chk_i  = {10'b0, n_q[9:0], n_q[31]};
      end
      S_SIMM13: begin
        chk_ok = fits_signed(n_q, 13);
        chk_i  = {7'b0, n_q[12:0], n_q[31]};
      end
      S_HI21: begin
        chk_ok = n_q[10:0] == '0;
        chk_i  = n_q[31:11];
      end
      S_ZERO:   chk_ok = n_q == '0;
      default:  chk_ok = 1'b0;
    endcase
  end

  // The shift field holds 31-amt, i.e. the bitwise complement of amt.
  always_comb begin
    n_d   = n_q;
    rb_d  = rb_q;
    s_d   = s_q;
    amt_d = amt_q;
    i_d   = i_q;
    ok_d  = ok_q;
    if (state_q == IDLE && bus.in_valid) begin
      n_d   = bus.N;
      rb_d  = bus.RB;
      s_d   = mode_e'(bus.S);
      amt_d = '0;
    end
    if (state_q == CHECK) begin
      ok_d = chk_ok;
      i_d  = chk_ok ? chk_i : '0;
    end
    if (state_q == SEARCH) begin
      amt_d = amt_q + SHAMT_W'(1);
      ok_d  = hit;
      i_d   = hit ? {11'b0, ~amt_q, 5'b0} : '0;
    end
  end

  always_comb begin
    bus.in_ready  = state_q == IDLE;
    bus.out_valid = state_q == DONE;
    bus.I         = i_q;
    bus.ok        = ok_q;
  end
endmodule

// File: tb/tb_operand_encoder.sv
// tb_operand_encoder: directed and random requests checked against an
// arithmetic model of the encoding rules, plus handshake and reset behaviour.
module tb_operand_encoder;
  import operand_encoder_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  operand_encoder_if bus ();
  operand_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sra(input logic [31:0] v, input int k);
    logic signed [31:0] t;
    t = v;
    return t >>> k;
  endfunction

  function automatic logic [31:0] shift(input logic [31:0] rb, input logic [2:0] s, input int k);
    if (s == 3'd4) return rb >> k;
    if (s == 3'd5) return sra(rb, k);
    return rb << k;
  endfunction

  function automatic void model(input logic [31:0] n, input logic [31:0] rb, input logic [2:0] s,
                                output logic ok, output logic [20:0] imm, output int lat);
    int sn;
    sn = $signed(n);
    ok = 1'b0;
    imm = '0;
    lat = 2;
    case (s)
      3'd0: ok = n == rb;
      3'd1: begin
        ok = sn >= -512 && sn <= 511;
        if (ok) imm = 21'((n % 1024) * 2 + (sn < 0 ? 1 : 0));
      end
      3'd2: begin
        ok = sn >= -4096 && sn <= 4095;
        if (ok) imm = 21'((n % 8192) * 2 + (sn < 0 ? 1 : 0));
      end
      3'd3: begin
        ok = n % 2048 == 0;
        if (ok) imm = 21'(n / 2048);
      end
      3'd7: ok = n == 0;
      default: begin
        lat = 33;
        for (int k = 0; k < 32 && !ok; k++)
          if (shift(rb, s, k) == n) begin
            ok = 1'b1;
            imm = 21'((31 - k) * 32);
            lat = 2 + k;
          end
      end
    endcase
  endfunction

  function automatic logic [31:0] decode(input logic [20:0] imm, input logic [31:0] rb, input logic [2:0] s);
    logic [31:0] v;
    case (s)
      3'd0: v = rb;
      3'd1: begin
        v = 32'((imm / 2) % 1024);
        if (imm[0]) v = v - 1024;
      end
      3'd2: begin
        v = 32'((imm / 2) % 8192);
        if (imm[0]) v = v - 8192;
      end
      3'd3: v = 32'(imm) * 2048;
      3'd7: v = '0;
      default: v = shift(rb, s, 31 - int'((imm / 32) % 32));
    endcase
    return v;
  endfunction

  task automatic xact(input logic [31:0] n, input logic [31:0] rb, input logic [2:0] s,
                      input int stall, input bit flood,
                      output logic o_ok, output logic [20:0] o_i, output int o_lat);
    int lat;
    @(negedge clk);
    check("idle_rdy", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.N = n;
    bus.RB = rb;
    bus.S = s;
    @(posedge clk);
    #1;
    lat = 1;
    bus.in_valid = flood;
    bus.N = $urandom;
    bus.RB = $urandom;
    bus.S = 3'($urandom);
    while (!bus.out_valid && lat < 40) begin
      check("busy_rdy", bus.in_ready, 0);
      @(posedge clk);
      #1;
      lat++;
      bus.in_valid = flood ? 1'($urandom) : 1'b0;
      bus.N = $urandom;
      bus.RB = $urandom;
    end
    check("out_valid", bus.out_valid, 1);
    o_ok = bus.ok;
    o_i = bus.I;
    o_lat = lat;
    for (int c = 0; c < stall; c++) begin
      @(posedge clk);
      #1;
      check("hold_v", bus.out_valid, 1);
      check("hold_i", bus.I, o_i);
      check("hold_ok", bus.ok, o_ok);
      check("done_rdy", bus.in_ready, 0);
      bus.in_valid = flood ? 1'($urandom) : 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    check("drop_v", bus.out_valid, 0);
    check("back_idle", bus.in_ready, 1);
    if (o_ok) check("roundtrip", decode(o_i, rb, s), n);
  endtask

  initial begin
    logic ok, e_ok;
    logic [20:0] imm, e_imm;
    int lat, e_lat, seen;
    logic [31:0] n, rb;
    logic [2:0] s;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.N = '0;
    bus.RB = '0;
    bus.S = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", bus.in_ready, 1);
    check("rst_v", bus.out_valid, 0);
    check("rst_i", bus.I, 0);
    check("rst_ok", bus.ok, 0);
    rst_n = 1'b1;

    xact(32'hFFFFFE00, 32'h0, 3'd1, 0, 1'b0, ok, imm, lat);
    check("s1_ok", ok, 1); check("s1_i", imm, 21'h000401); check("s1_lat", lat, 2);
    xact(32'h00000400, 32'h0, 3'd1, 0, 1'b0, ok, imm, lat);
    check("s1n_ok", ok, 0); check("s1n_i", imm, 0);
    xact(32'hABCDE800, 32'h0, 3'd3, 1, 1'b0, ok, imm, lat);
    check("s3_ok", ok, 1); check("s3_i", imm, 21'h1579BD); check("s3_lat", lat, 2);
    xact(32'h10, 32'h1, 3'd6, 0, 1'b1, ok, imm, lat);
    check("s6_ok", ok, 1); check("s6_i", imm, 21'h000360); check("s6_lat", lat, 6);
    xact(32'h1, 32'h80000000, 3'd4, 0, 1'b0, ok, imm, lat);
    check("s4_ok", ok, 1); check("s4_i", imm, 0); check("s4_lat", lat, 33);
    xact(32'h1, 32'h80000000, 3'd5, 5, 1'b1, ok, imm, lat);
    check("s5_ok", ok, 0); check("s5_i", imm, 0); check("s5_lat", lat, 33);

    for (int t = 0; t < 80; t++) begin
      s = 3'($urandom);
      rb = $urandom;
      n = $urandom;
      case (s)
        3'd0: if ($urandom_range(1) == 1) n = rb;
        3'd1: if ($urandom_range(1) == 1) n = 32'($urandom_range(1025)) - 513;
        3'd2: if ($urandom_range(1) == 1) n = 32'($urandom_range(8193)) - 4097;
        3'd3: if ($urandom_range(1) == 1) n = n & ~32'h7FF;
        3'd7: if ($urandom_range(1) == 1) n = '0;
        default: if ($urandom_range(3) != 0) n = shift(rb, s, int'($urandom_range(31)));
      endcase
      model(n, rb, s, e_ok, e_imm, e_lat);
      xact(n, rb, s, int'($urandom_range(3)), 1'($urandom), ok, imm, lat);
      check("rnd_ok", ok, e_ok);
      check("rnd_i", imm, e_imm);
      check("rnd_lat", lat, e_lat);
    end

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.N = 32'h1;
    bus.RB = 32'h80000000;
    bus.S = 3'd4;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_rdy", bus.in_ready, 1);
    check("abort_v", bus.out_valid, 0);
    check("abort_i", bus.I, 0);
    check("abort_ok", bus.ok, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      seen |= int'(bus.out_valid);
    end
    check("no_pulse", seen, 0);
    check("post_rdy", bus.in_ready, 1);

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.N = 32'h5;
    bus.S = 3'd1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pre_done_v", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("done_abort_v", bus.out_valid, 0);
    check("done_abort_rdy", bus.in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
